// File: rtl/project_select_pkg.sv
// Shared encodings for the multi-project pad-bank selector.
// The firmware and the pad mux also use these encodings.
package project_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int unsigned PROJ_ID_0 = 0;
  localparam int unsigned PROJ_ID_1 = 1;
  localparam int unsigned PROJ_ID_2 = 2;
  localparam int unsigned PROJ_ID_3 = 3;
  localparam int unsigned PROJ_ID_4 = 4;
  localparam int unsigned PROJ_ID_5 = 5;
  localparam int unsigned PROJ_ID_6 = 6;
  localparam int unsigned PROJ_ID_7 = 7;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag. It stops at zero and never wraps.
// The DRAIN and HOLD phases of the selector both use this counter.
module cycle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/project_select_ctrl.sv
// Grants the shared user-area pads to one project at a time.
// Every other project is held in reset. A switch runs tristate, drain, remap, hold, then release.
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int unsigned NUM_PROJ     = 8,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sel_req_valid,
  input  logic [SEL_W-1:0]    sel_req_id,
  output logic                sel_req_ready,
  output logic [SEL_W-1:0]    active_id,
  output logic                active_valid,
  output logic [NUM_PROJ-1:0] proj_reset,
  output logic                busy,
  output logic                err_bad_id
);

  state_t           state;
  logic [SEL_W-1:0] next_id;

  logic             accept_c;
  logic             id_ok_c;
  logic             tmr_load_c;
  logic             tmr_count_c;
  logic             tmr_zero_c;
  logic [CNT_W-1:0] tmr_val_c;

  // Decode requests and derive the timer controls from the current state.
  always_comb begin
    accept_c    = (state == ST_IDLE) && sel_req_valid;
    id_ok_c     = 32'(sel_req_id) < NUM_PROJ;
    tmr_load_c  = 1'b0;
    tmr_count_c = 1'b0;
    tmr_val_c   = CNT_W'(DRAIN_CYCLES - 1);
    case (state)
      ST_IDLE:   tmr_load_c = accept_c && id_ok_c;
      ST_DRAIN:  tmr_count_c = 1'b1;
      ST_SWITCH: begin
        tmr_load_c = 1'b1;
        tmr_val_c  = CNT_W'(RESET_CYCLES - 1);
      end
      ST_HOLD:   tmr_count_c = 1'b1;
      default:   tmr_load_c = 1'b0;
    endcase
  end

  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .count    (tmr_count_c),
    .zero_c   (tmr_zero_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      next_id       <= '0;
      active_id     <= SEL_W'(PROJ_ID_0);
      active_valid  <= 1'b0;
      proj_reset    <= '1;
      err_bad_id    <= 1'b0;
      sel_req_ready <= 1'b1;
      busy          <= 1'b0;
    end else begin
      err_bad_id <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c && !id_ok_c) begin
            err_bad_id <= 1'b1;
          end else if (accept_c) begin
            next_id       <= sel_req_id;
            active_valid  <= 1'b0;
            proj_reset    <= proj_reset | (NUM_PROJ'(1) << active_id);
            sel_req_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_DRAIN;
          end
        end
        // The remap is registered on the DRAIN exit so the new select is visible during the SWITCH cycle.
        ST_DRAIN: begin
          if (tmr_zero_c) begin
            active_id <= next_id;
            state     <= ST_SWITCH;
          end
        end
        ST_SWITCH: state <= ST_HOLD;
        ST_HOLD: begin
          if (tmr_zero_c) begin
            proj_reset    <= ~(NUM_PROJ'(1) << next_id);
            active_valid  <= 1'b1;
            sel_req_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Randomized and directed checks of project_select_ctrl against a timeline model.
// The model places each switch event at a cycle offset from the accepting cycle.
module tb_project_select_ctrl;

  localparam int unsigned NUM_PROJ     = 8;
  localparam int unsigned SEL_W        = 4;
  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned RESET_CYCLES = 16;
  localparam int unsigned CNT_W        = 8;
  localparam int          SW_DONE      = DRAIN_CYCLES + RESET_CYCLES + 2;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                sel_req_valid = 1'b0;
  logic [SEL_W-1:0]    sel_req_id = '0;
  logic                sel_req_ready;
  logic [SEL_W-1:0]    active_id;
  logic                active_valid;
  logic [NUM_PROJ-1:0] proj_reset;
  logic                busy;
  logic                err_bad_id;

  int checks = 0;
  int failures = 0;

  // Model state: the committed project plus an optional in-flight switch.
  int cyc = 0;
  bit sw_busy;
  int sw_start;
  int sw_old;
  int sw_new;
  int cur_id;
  bit cur_valid;
  int err_at;

  project_select_ctrl #(
    .NUM_PROJ     (NUM_PROJ),
    .SEL_W        (SEL_W),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .RESET_CYCLES (RESET_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sel_req_valid (sel_req_valid),
    .sel_req_id    (sel_req_id),
    .sel_req_ready (sel_req_ready),
    .active_id     (active_id),
    .active_valid  (active_valid),
    .proj_reset    (proj_reset),
    .busy          (busy),
    .err_bad_id    (err_bad_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic reset_model();
    sw_busy   = 1'b0;
    sw_start  = 0;
    sw_old    = 0;
    sw_new    = 0;
    cur_id    = 0;
    cur_valid = 1'b0;
    err_at    = -1;
  endtask

  task automatic check_outputs(input string ph);
    int k;
    int exp_id;
    logic [NUM_PROJ-1:0] exp_rst;
    k = cyc - sw_start;
    for (int i = 0; i < int'(NUM_PROJ); i++)
      exp_rst[i] = !(!sw_busy && cur_valid && (i == cur_id));
    exp_id = sw_busy ? ((k >= int'(DRAIN_CYCLES) + 1) ? sw_new : sw_old) : cur_id;
    check_eq({ph, ".ready"}, 32'(sel_req_ready), 32'(!sw_busy));
    check_eq({ph, ".busy"}, 32'(busy), 32'(sw_busy));
    check_eq({ph, ".active_valid"}, 32'(active_valid), 32'(!sw_busy && cur_valid));
    check_eq({ph, ".active_id"}, 32'(active_id), 32'(exp_id));
    check_eq({ph, ".proj_reset"}, 32'(proj_reset), 32'(exp_rst));
    check_eq({ph, ".err_bad_id"}, 32'(err_bad_id), 32'(cyc == err_at));
  endtask

  task automatic model_edge(input bit acc, input int id);
    cyc++;
    if (acc) begin
      if (id >= int'(NUM_PROJ)) begin
        err_at = cyc;
      end else begin
        sw_busy  = 1'b1;
        sw_start = cyc - 1;
        sw_old   = cur_id;
        sw_new   = id;
      end
    end
    if (sw_busy && (cyc - sw_start >= SW_DONE)) begin
      sw_busy   = 1'b0;
      cur_id    = sw_new;
      cur_valid = 1'b1;
    end
  endtask

  // One clock: check at negedge, advance the model, then pick the next inputs.
  task automatic run_cycle(input bit rnd);
    bit acc;
    int id;
    @(negedge clk);
    check_outputs(rnd ? "rnd" : "dir");
    acc = sel_req_valid && !sw_busy;
    id  = int'(sel_req_id);
    @(posedge clk);
    #1;
    model_edge(acc, id);
    if (rnd) begin
      if (!(sel_req_valid && !acc && ($urandom_range(3) != 0))) begin
        sel_req_valid = ($urandom_range(5) == 0);
        sel_req_id    = SEL_W'($urandom_range(11));
      end
    end else if (acc) begin
      sel_req_valid = 1'b0;
    end
  endtask

  initial begin
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset: no project runs
    repeat (6) run_cycle(1'b0);

    // Switch to 2, then a held request for 5 issued while busy
    sel_req_valid = 1'b1;
    sel_req_id    = SEL_W'(2);
    run_cycle(1'b0);
    repeat (3) run_cycle(1'b0);
    sel_req_valid = 1'b1;
    sel_req_id    = SEL_W'(5);
    repeat (60) run_cycle(1'b0);

    // Out-of-range id
    sel_req_valid = 1'b1;
    sel_req_id    = SEL_W'(9);
    repeat (4) run_cycle(1'b0);

    // Re-select the current project
    sel_req_valid = 1'b1;
    sel_req_id    = SEL_W'(5);
    repeat (26) run_cycle(1'b0);

    repeat (1500) run_cycle(1'b1);

    // Async reset in the middle of HOLD
    sel_req_valid = 1'b0;
    repeat (30) run_cycle(1'b0);
    sel_req_valid = 1'b1;
    sel_req_id    = SEL_W'(3);
    repeat (12) run_cycle(1'b0);
    check_eq("pre_rst.busy", 32'(busy), 32'(1));
    #2;
    reset_n = 1'b0;
    sel_req_valid = 1'b0;
    #1;
    check_eq("async_rst.proj_reset", 32'(proj_reset), 32'(8'hFF));
    check_eq("async_rst.active_valid", 32'(active_valid), 32'(0));
    check_eq("async_rst.busy", 32'(busy), 32'(0));
    check_eq("async_rst.active_id", 32'(active_id), 32'(0));
    reset_model();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) run_cycle(1'b0);
    sel_req_valid = 1'b1;
    sel_req_id    = SEL_W'(6);
    repeat (26) run_cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
